// File: rtl/mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// mac_dot_ctrl
// Job sequencer for one 16x16->32 pipelined signed MAC instance. A job loads
// a bias into the MAC accumulator, streams LEN operand pairs through a
// valid/ready port, flushes the two product stages of the MAC and then holds
// the accumulated dot product on a valid/ready result port until taken.
//
// The MAC itself lives outside this block; its Result port (the accumulator
// register) is fed back on mac_result and forwarded as out_data in DONE.
//
// All outputs are decoded from the registered state. The two intended
// combinational paths are:
//   - in_valid -> mac_en while streaming, so an idle source freezes the MAC
//     pipeline for that cycle instead of pushing a bogus product;
//   - in_x/in_y -> mac_x/mac_y while streaming, the operand pass-through.
// abort and rst only act through the next state, never on outputs directly.
// ---------------------------------------------------------------------------
module mac_dot_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,

    // job control
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    input  logic              abort,

    // operand stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,

    // MAC control / data
    output logic              mac_en,
    output logic              mac_acc_load,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_y,
    output logic [ACC_W-1:0]  mac_z,
    input  logic [ACC_W-1:0]  mac_result,

    // result stream
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,

    // status
    output logic              busy
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;

    // pairs still to be accepted in the current job
    logic [LEN_W-1:0]  count_r;
    // bias captured with start, driven onto mac_z during LOAD
    logic [ACC_W-1:0]  bias_r;

    // decoded helpers
    logic              capture_s;   // start accepted in IDLE this cycle
    logic              accept_s;    // operand pair handshake this cycle
    logic              last_pair_s; // the accept that completes the job

    // -----------------------------------------------------------------------
    // Handshake / capture decode
    // -----------------------------------------------------------------------

    // Decode job capture and pair acceptance; abort suppresses both.
    always_comb begin
        capture_s   = 1'b0;
        accept_s    = 1'b0;
        last_pair_s = 1'b0;
        if (abort) begin
            capture_s   = 1'b0;
            accept_s    = 1'b0;
            last_pair_s = 1'b0;
        end else begin
            capture_s   = (state_r == ST_IDLE) && start;
            accept_s    = (state_r == ST_STREAM) && in_valid;
            last_pair_s = accept_s && (count_r == LEN_ONE);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------

    // Job sequencing; abort overrides every other transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // an empty job still reports the bias as its result
                    if (count_r != LEN_ZERO) begin
                        state_s = ST_STREAM;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                ST_STREAM: begin
                    if (last_pair_s) begin
                        state_s = ST_DRAIN1;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end
                ST_DRAIN1: begin
                    state_s = ST_DRAIN2;
                end
                ST_DRAIN2: begin
                    state_s = ST_DONE;
                end
                ST_DONE: begin
                    // start is deliberately not looked at here
                    if (out_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State and job registers
    // -----------------------------------------------------------------------

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Remaining-pair counter: loaded with start, decremented per accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= LEN_ZERO;
        end else if (capture_s) begin
            count_r <= len;
        end else if (accept_s) begin
            count_r <= count_r - LEN_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Bias capture register, only written when a job is started.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_r <= ACC_ZERO;
        end else if (capture_s) begin
            bias_r <= bias;
        end else begin
            bias_r <= bias_r;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------

    // Outputs decoded from state; everything is zero unless a state drives it.
    always_comb begin
        in_ready     = 1'b0;
        mac_en       = 1'b0;
        mac_acc_load = 1'b0;
        mac_x        = DATA_ZERO;
        mac_y        = DATA_ZERO;
        mac_z        = ACC_ZERO;
        out_valid    = 1'b0;
        out_data     = ACC_ZERO;
        busy         = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                // acc_load also clears both product stages inside the MAC
                mac_en       = 1'b1;
                mac_acc_load = 1'b1;
                mac_z        = bias_r;
            end
            ST_STREAM: begin
                // a missing operand freezes the MAC instead of adding zero
                in_ready = 1'b1;
                mac_en   = in_valid;
                mac_x    = in_x;
                mac_y    = in_y;
            end
            ST_DRAIN1: begin
                // zero operands push the last real products through
                mac_en = 1'b1;
            end
            ST_DRAIN2: begin
                mac_en = 1'b1;
            end
            ST_DONE: begin
                // mac_en is low, so the accumulator is stable while waiting
                out_valid = 1'b1;
                out_data  = mac_result;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_ctrl
// Directed bench for mac_dot_ctrl. A behavioural 2-stage pipelined signed MAC
// closes the loop on mac_result. Jobs come from a vector table with
// hand-computed results and latencies; abort/reset and start-priority corner
// cases are written out as short sequences.
// ---------------------------------------------------------------------------
module tb_mac_dot_ctrl;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 16;
    localparam int MAX_CYC = 60;

    logic              clk = 1'b0;
    logic              rst_s;
    logic              start_s;
    logic [LEN_W-1:0]  len_s;
    logic [ACC_W-1:0]  bias_s;
    logic              abort_s;
    logic              in_valid_s;
    logic              in_ready_s;
    logic [DATA_W-1:0] in_x_s;
    logic [DATA_W-1:0] in_y_s;
    logic              mac_en_s;
    logic              mac_acc_load_s;
    logic [DATA_W-1:0] mac_x_s;
    logic [DATA_W-1:0] mac_y_s;
    logic [ACC_W-1:0]  mac_z_s;
    logic [ACC_W-1:0]  mac_result_s;
    logic              out_valid_s;
    logic              out_ready_s;
    logic [ACC_W-1:0]  out_data_s;
    logic              busy_s;

    int n_chk  = 0;
    int n_fail = 0;

    // free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    mac_dot_ctrl #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst_s),
        .start       (start_s),
        .len         (len_s),
        .bias        (bias_s),
        .abort       (abort_s),
        .in_valid    (in_valid_s),
        .in_ready    (in_ready_s),
        .in_x        (in_x_s),
        .in_y        (in_y_s),
        .mac_en      (mac_en_s),
        .mac_acc_load(mac_acc_load_s),
        .mac_x       (mac_x_s),
        .mac_y       (mac_y_s),
        .mac_z       (mac_z_s),
        .mac_result  (mac_result_s),
        .out_valid   (out_valid_s),
        .out_ready   (out_ready_s),
        .out_data    (out_data_s),
        .busy        (busy_s)
    );

    // Behavioural MAC: product stage 1 -> stage 2 -> accumulator.
    logic signed [ACC_W-1:0] m_p1_r  = 32'sd0;
    logic signed [ACC_W-1:0] m_p2_r  = 32'sd0;
    logic signed [ACC_W-1:0] m_acc_r = 32'sd0;
    assign mac_result_s = m_acc_r;

    // MAC model: acc_load seeds acc with Z and clears both product stages.
    always @(posedge clk) begin
        if (mac_en_s) begin
            if (mac_acc_load_s) begin
                m_acc_r <= mac_z_s;
                m_p1_r  <= 32'sd0;
                m_p2_r  <= 32'sd0;
            end else begin
                m_p1_r  <= $signed(mac_x_s) * $signed(mac_y_s);
                m_p2_r  <= m_p1_r;
                m_acc_r <= m_acc_r + m_p2_r;
            end
        end
    end

    typedef struct {
        string              name;
        int                 len;
        logic [ACC_W-1:0]   bias;
        logic [3:0][15:0]   xs;
        logic [3:0][15:0]   ys;
        int                 stall_after;
        int                 stall_cyc;
        int                 hold;
        logic [ACC_W-1:0]   exp_data;
        int                 exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one job from a table entry and check latency, result and handshakes.
    task automatic run_job(input vec_t v);
        int  k;
        int  p;
        int  rdy_seen;
        int  stall_left;
        logic acc_now;
        start_s  = 1'b1;
        len_s    = v.len[15:0];
        bias_s   = v.bias;
        step();                       // edge c: start sampled
        start_s  = 1'b0;
        k        = 1;
        p        = 0;
        rdy_seen = 0;
        stall_left = v.stall_cyc;
        chk({v.name, "_load_flag"}, {31'd0, mac_acc_load_s & mac_en_s}, 32'd1);
        chk({v.name, "_load_z"}, mac_z_s, v.bias);
        while (!out_valid_s && k <= MAX_CYC) begin
            in_valid_s = 1'b0;
            if (in_ready_s) begin
                rdy_seen++;
                if (p == v.stall_after && stall_left > 0) begin
                    stall_left--;
                end else if (p < 4) begin
                    in_valid_s = 1'b1;
                    in_x_s     = v.xs[p];
                    in_y_s     = v.ys[p];
                end
            end
            acc_now = in_valid_s & in_ready_s;
            step();
            k++;
            if (acc_now) p++;
            in_valid_s = 1'b0;
        end
        chk({v.name, "_out_valid"}, {31'd0, out_valid_s}, 32'd1);
        chk({v.name, "_latency"}, k, v.exp_lat);
        chk({v.name, "_out_data"}, out_data_s, v.exp_data);
        chk({v.name, "_pairs"}, p, v.len);
        chk({v.name, "_in_ready_cycles"}, rdy_seen, v.len + v.stall_cyc);
        for (int h = 0; h < v.hold; h++) begin
            start_s = (h == 2);
            step();
            start_s = 1'b0;
            chk({v.name, "_hold_valid"}, {31'd0, out_valid_s}, 32'd1);
            chk({v.name, "_hold_data"}, out_data_s, v.exp_data);
        end
        // start rides along with the handshake when holding; it must be ignored
        out_ready_s = 1'b1;
        start_s     = (v.hold > 0);
        step();
        out_ready_s = 1'b0;
        start_s     = 1'b0;
        chk({v.name, "_post_busy"}, {31'd0, busy_s}, 32'd0);
        chk({v.name, "_post_valid"}, {31'd0, out_valid_s}, 32'd0);
    endtask

    // Kill a 4-pair job after 2 accepted pairs, by abort or by rst.
    task automatic kill_mid(input bit use_rst, input string name);
        start_s = 1'b1;
        len_s   = 16'd4;
        bias_s  = 32'd10;
        step();                       // LOAD
        start_s = 1'b0;
        step();                       // STREAM
        in_valid_s = 1'b1;
        in_x_s = 16'd1; in_y_s = 16'd2;
        step();
        in_x_s = 16'd3; in_y_s = 16'd4;
        step();
        chk({name, "_mid_busy"}, {31'd0, busy_s}, 32'd1);
        if (use_rst) rst_s = 1'b1;
        else         abort_s = 1'b1;
        in_x_s = 16'd5; in_y_s = 16'd6;
        step();
        rst_s = 1'b0;
        abort_s = 1'b0;
        in_valid_s = 1'b0;
        chk({name, "_busy"}, {31'd0, busy_s}, 32'd0);
        chk({name, "_out_valid"}, {31'd0, out_valid_s}, 32'd0);
        chk({name, "_in_ready"}, {31'd0, in_ready_s}, 32'd0);
        step();
        chk({name, "_stay_idle"}, {31'd0, busy_s}, 32'd0);
    endtask

    initial begin
        //          name   len bias            xs (idx3..0)                              ys (idx3..0)                              sa sc hold exp             lat
        vecs[0] = '{"T1", 4, 32'd10,         {16'd7, 16'd5, 16'd3, 16'd1},           {16'd8, 16'd6, 16'd4, 16'd2},           0, 0, 0, 32'd110,         8};
        vecs[1] = '{"T2", 4, 32'd10,         {16'd7, 16'd5, 16'd3, 16'd1},           {16'd8, 16'd6, 16'd4, 16'd2},           2, 3, 0, 32'd110,         11};
        vecs[2] = '{"T3", 0, 32'hFFFF_FFFB,  {16'd0, 16'd0, 16'd0, 16'd0},           {16'd0, 16'd0, 16'd0, 16'd0},           0, 0, 0, 32'hFFFF_FFFB,   2};
        vecs[3] = '{"T4", 2, 32'd0,          {16'd0, 16'd0, 16'h8000, 16'h8000},     {16'd0, 16'd0, 16'h8000, 16'h8000},     0, 0, 0, 32'h8000_0000,   6};
        vecs[4] = '{"T5", 4, 32'd10,         {16'd7, 16'd5, 16'd3, 16'd1},           {16'd8, 16'd6, 16'd4, 16'd2},           0, 0, 5, 32'd110,         8};
        vecs[5] = '{"T7", 1, 32'd100,        {16'd0, 16'd0, 16'd0, 16'hFFFD},        {16'd0, 16'd0, 16'd0, 16'd7},           0, 0, 0, 32'd79,          5};
        vecs[6] = '{"T8", 3, 32'hFFFF_FFFF,  {16'd0, 16'd0, 16'hFF38, 16'd1000},     {16'd0, 16'd5, 16'd50, 16'd1000},       0, 0, 0, 32'h000F_1B2F,   7};

        rst_s = 1'b1; start_s = 1'b1; len_s = 16'd3; bias_s = 32'd7;
        abort_s = 1'b0; in_valid_s = 1'b1; in_x_s = 16'd9; in_y_s = 16'd9;
        out_ready_s = 1'b0;
        repeat (3) step();
        chk("rst_busy",      {31'd0, busy_s},         32'd0);
        chk("rst_out_valid", {31'd0, out_valid_s},    32'd0);
        chk("rst_in_ready",  {31'd0, in_ready_s},     32'd0);
        chk("rst_mac_en",    {31'd0, mac_en_s},       32'd0);
        chk("rst_acc_load",  {31'd0, mac_acc_load_s}, 32'd0);
        chk("rst_mac_z",     mac_z_s,                 32'd0);
        chk("rst_mac_xy",    {mac_x_s, mac_y_s},      32'd0);
        chk("rst_out_data",  out_data_s,              32'd0);
        rst_s = 1'b0; start_s = 1'b0; in_valid_s = 1'b0;
        step();

        // abort wins over start in IDLE
        abort_s = 1'b1; start_s = 1'b1;
        step();
        abort_s = 1'b0; start_s = 1'b0;
        chk("abort_vs_start", {31'd0, busy_s}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
        end

        kill_mid(1'b0, "T6_abort");
        run_job(vecs[0]);
        kill_mid(1'b1, "T6_rst");
        run_job(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
